// File: rtl/tt_um_nibble_tx.sv
// Serial byte transmitter: start, 8 data bits LSB first, optional even parity, stop.
// tx goes low one cycle after acceptance; start is ignored while busy, with done pulsing one cycle per frame.
module tt_um_nibble_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);

    state_t     state, state_n;
    logic [7:0] baud, baud_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shreg, shreg_n;
    logic       par, par_n;
    logic       tx, tx_n;
    logic       busy, busy_n;
    logic       done, done_n;
    logic       start;
    logic       bit_end;
    logic       unused_inputs;

    assign start         = uio_in[0];
    assign bit_end       = (baud == LAST_TICK);
    assign unused_inputs = &{1'b0, ena, uio_in[7:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= 8'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            par     <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            par     <= par_n;
            tx      <= tx_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        par_n     = par;
        tx_n      = tx;
        busy_n    = busy;
        done_n    = 1'b0;

        if (state != IDLE) begin
            baud_n = bit_end ? 8'd0 : baud + 8'd1;
        end

        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (start) begin
                    state_n   = START;
                    shreg_n   = ui_in;
                    par_n     = ^ui_in;
                    baud_n    = 8'd0;
                    bit_idx_n = 3'd0;
                    tx_n      = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        // Index stays at 7 until the next acceptance reloads it.
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = par;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign uo_out  = {5'b00000, done, busy, tx};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_nibble_tx.sv
// Scoreboarded bench: a 16-clk parity instance and a 2-clk no-parity instance share clock and reset.
module tb_tt_um_nibble_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ui0 = 8'h00, ui1 = 8'h00;
    logic [7:0] uio_in0 = 8'h00, uio_in1 = 8'h00;
    logic [7:0] uo0, uo1, uio_out0, uio_out1, uio_oe0, uio_oe1;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    tt_um_nibble_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1)) dut0 (
        .clk(clk), .reset(reset), .ui_in(ui0), .uio_in(uio_in0),
        .uo_out(uo0), .uio_out(uio_out0), .uio_oe(uio_oe0), .ena(1'b1)
    );

    tt_um_nibble_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0)) dut1 (
        .clk(clk), .reset(reset), .ui_in(ui1), .uio_in(uio_in1),
        .uo_out(uo1), .uio_out(uio_out1), .uio_oe(uio_oe1), .ena(1'b1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] uo(input int w);
        return (w != 0) ? uo1 : uo0;
    endfunction

    task automatic set_in(input int w, input logic [7:0] data, input logic st);
        if (w != 0) begin
            ui1 = data;
            uio_in1 = {7'b1010101, st};
        end else begin
            ui0 = data;
            uio_in0 = {7'b0101010, st};
        end
    endtask

    // Called at a falling edge; start is raised now and accepted at the next rising edge.
    task automatic run_frame(input int w, input logic [7:0] data, input bit hold, input bit scramble);
        int   cpb;
        bit   par_en;
        logic b;
        cpb    = (w != 0) ? 2 : 16;
        par_en = (w == 0);
        set_in(w, data, 1'b1);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
        if (par_en) exp_q.push_back(^data);
        exp_q.push_back(1'b1);
        @(negedge clk);
        set_in(w, scramble ? 8'($urandom) : data, hold);
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            for (int c = 0; c < cpb; c++) begin
                check("tx", {31'd0, uo(w)[0]}, {31'd0, b});
                check("busy", {31'd0, uo(w)[1]}, 32'd1);
                check("done_early", {31'd0, uo(w)[2]}, 32'd0);
                @(negedge clk);
            end
        end
        check("done_pulse", {31'd0, uo(w)[2]}, 32'd1);
        check("done_busy", {31'd0, uo(w)[1]}, 32'd0);
        check("done_tx", {31'd0, uo(w)[0]}, 32'd1);
        check("hi_bits", {27'd0, uo(w)[7:3]}, 32'd0);
    endtask

    task automatic check_idle(input int w, input string tag);
        check(tag, {24'd0, uo(w)}, 32'h01);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check_idle(0, "idle0");
            check_idle(1, "idle1");
            check("uio_out", {16'd0, uio_out0, uio_out1}, 32'd0);
            check("uio_oe", {16'd0, uio_oe0, uio_oe1}, 32'd0);
            @(negedge clk);
        end

        run_frame(0, 8'hA5, 1'b0, 1'b1);
        @(negedge clk);
        check_idle(0, "after_a5");

        run_frame(0, 8'h07, 1'b0, 1'b1);
        @(negedge clk);
        run_frame(0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_idle(0, "after_00");

        // Held start: second frame accepted on the done cycle.
        run_frame(0, 8'h3C, 1'b1, 1'b0);
        run_frame(0, 8'hC3, 1'b0, 1'b1);
        @(negedge clk);
        check_idle(0, "after_c3");

        // Abort in the middle of data bit 4.
        set_in(0, 8'h96, 1'b1);
        @(negedge clk);
        set_in(0, 8'h96, 1'b0);
        repeat (87) @(negedge clk);
        check("pre_abort_busy", {31'd0, uo0[1]}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_idle(0, "abort0");
        check_idle(1, "abort1");
        reset = 1'b0;
        run_frame(0, 8'h5A, 1'b0, 1'b1);
        @(negedge clk);
        check_idle(0, "after_5a");

        run_frame(1, 8'hFF, 1'b0, 1'b1);
        @(negedge clk);
        check_idle(1, "after_ff");
        run_frame(1, 8'h81, 1'b0, 1'b0);
        @(negedge clk);
        check_idle(1, "after_81");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tt_um_nibble_tx.md
TT_UM_NIBBLE_TX -- requirements
Module: tt_um_nibble_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit; legal values are 2..255.
REQ-003 The block SHALL have parameter PARITY_EN, default 1; 1 inserts an even-parity bit, 0 omits it.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 ui_in  input  8  payload byte, sampled only when a frame is accepted.
REQ-007 uio_in  input  8  bit 0 = start request (level); bits 7:1 ignored.
REQ-008 uo_out  output  8  bit 0 = tx line; bit 1 = busy; bit 2 = done pulse; bits 7:3 = 0.
REQ-009 uio_out  output  8  constant 0.
REQ-010 uio_oe  output  8  constant 0, so all uio pins are inputs.
REQ-011 ena  input  1  ignored.

Function
REQ-012 The block SHALL be a serial transmitter framing one byte as: start bit (0), data bits 0..7 LSB first, optional parity bit, stop bit (1).
REQ-013 The states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 Transitions SHALL be:
- IDLE->START on start=1.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->PARITY (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) after 8 bits.
- PARITY->STOP after CLKS_PER_BIT cycles.
- STOP->IDLE after CLKS_PER_BIT cycles.
REQ-015 In IDLE, a rising edge with start=1 SHALL accept a frame, latch ui_in into an 8-bit shift register, and enter START.
REQ-016 tx SHALL be registered; tx=0 from the cycle after acceptance.
REQ-017 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, timed by an 8-bit baud counter reloaded at every bit boundary.
REQ-018 A 3-bit bit index SHALL count data bits 0..7; the index SHALL not wrap within a frame.
REQ-019 The parity bit SHALL be the XOR of the 8 latched data bits (even parity).
REQ-020 busy SHALL be 1 from the cycle after acceptance through the last cycle of the stop bit, and 0 otherwise.
REQ-021 done SHALL pulse high for exactly one cycle: the first cycle after the stop bit completes, with state IDLE and busy=0.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 Changes on ui_in after acceptance SHALL not affect the frame in flight.
REQ-024 start held high continuously SHALL produce back-to-back frames, each accepted on the cycle done=1, giving exactly 1 idle cycle (tx=1) between frames.
REQ-025 Frame length SHALL be 11*CLKS_PER_BIT cycles with parity and 10*CLKS_PER_BIT cycles without.
REQ-026 tx SHALL be 1 in IDLE.

Reset
REQ-027 At a rising edge with reset=1 the block SHALL, on the next cycle, set: state IDLE, tx=1, busy=0, done=0, counters 0, shift register 0.
REQ-028 Reset SHALL take priority over start and abort any frame in progress without a done pulse.
REQ-029 The first frame after reset release SHALL be accepted on the first edge with reset=0 and start=1.

Verification
REQ-030 Reset, then idle 20 cycles -> tx=1, busy=0, done=0, uo_out[7:3]=0, uio_out=0, uio_oe=0 throughout.
REQ-031 CLKS_PER_BIT=16, PARITY_EN=1, ui_in=0xA5, 1-cycle start pulse -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 16 cycles; busy for 176 cycles; done on cycle 177.
REQ-032 ui_in=0x07, PARITY_EN=1 -> parity bit 1; ui_in=0x00 -> parity bit 0, data bits all 0.
REQ-033 start held high, ui_in=0x3C then 0xC3 -> two frames with exactly one tx=1 idle cycle between them; second frame carries 0xC3.
REQ-034 Assert reset during data bit 4 -> next cycle tx=1, busy=0, no done pulse; a following start with ui_in=0x5A transmits a complete, correct frame.
REQ-035 PARITY_EN=0, CLKS_PER_BIT=2, ui_in=0xFF -> 20-cycle frame (0, eight 1s, stop 1), no parity bit; done on cycle 21.
